// File: rtl/reverb_mix_pkg.sv
// Shared types and constants for the reverb mixer: FSM states, widths and
// the ramp-scaled gain helper.
package reverb_mix_pkg;

  localparam int SAMPLE_W = 16;
  localparam int DELAY_W  = 13;
  localparam int GAIN_W   = 8;
  localparam int RAMP_W   = 9;
  localparam int PROD_W   = SAMPLE_W + GAIN_W;

  localparam logic [RAMP_W-1:0] RAMP_MAX  = 9'd256;
  localparam logic [RAMP_W-1:0] RAMP_STEP = 9'd16;

  typedef enum logic [1:0] {
    ST_RUN      = 2'd0,
    ST_FADE_OUT = 2'd1,
    ST_FLUSH    = 2'd2,
    ST_FADE_IN  = 2'd3
  } mix_state_e;

  // (gain * ramp) >> 8; result never exceeds 255 because ramp tops out at 256
  function automatic logic [RAMP_W-1:0] scale_gain(input logic [GAIN_W-1:0] gain,
                                                   input logic [RAMP_W-1:0] ramp);
    return RAMP_W'(({{RAMP_W{1'b0}}, gain} * {{GAIN_W{1'b0}}, ramp}) >> GAIN_W);
  endfunction

endpackage

// File: rtl/sat_add16.sv
// Signed 16-bit adder that clamps to the representable range instead of wrapping.
module sat_add16
  import reverb_mix_pkg::*;
(
  input  logic signed [SAMPLE_W-1:0] a,
  input  logic signed [SAMPLE_W-1:0] b,
  output logic signed [SAMPLE_W-1:0] sum
);

  logic signed [SAMPLE_W:0] wide_s;

  // Top two bits of the 17-bit sum disagree exactly when the result overflows
  always_comb begin
    wide_s = {a[SAMPLE_W-1], a} + {b[SAMPLE_W-1], b};
    case (wide_s[SAMPLE_W:SAMPLE_W-1])
      2'b01:   sum = {1'b0, {(SAMPLE_W-1){1'b1}}};
      2'b10:   sum = {1'b1, {(SAMPLE_W-1){1'b0}}};
      default: sum = wide_s[SAMPLE_W-1:0];
    endcase
  end

endmodule

// File: rtl/reverb_mix.sv
// Feedback/wet mixer for a delay-line reverb. Delay length changes are hidden
// behind a fade-out, flush of the delay line and fade-in of the wet/feedback gains.
module reverb_mix
  import reverb_mix_pkg::*;
(
  input  logic                clk,
  input  logic                reset_n,
  input  logic                sample_en,
  input  logic [SAMPLE_W-1:0] dry_in,
  input  logic [SAMPLE_W-1:0] delayed_in,
  input  logic [GAIN_W-1:0]   fb_gain,
  input  logic [GAIN_W-1:0]   wet_gain,
  input  logic [DELAY_W-1:0]  delay_req,
  output logic [DELAY_W-1:0]  delay_sel,
  output logic [SAMPLE_W-1:0] fb_out,
  output logic [SAMPLE_W-1:0] out,
  output logic                out_valid
);

  mix_state_e          state_r;
  logic [RAMP_W-1:0]   ramp_r;
  logic [DELAY_W-1:0]  delay_sel_r;
  logic [DELAY_W-1:0]  cnt_r;
  logic [DELAY_W-1:0]  cnt_next_s;

  logic                       v0_r, v1_r;
  logic signed [SAMPLE_W-1:0] dry0_r, dly0_r, dry1_r;
  logic [RAMP_W-1:0]          gfb0_r, gwet0_r;
  logic signed [PROD_W-1:0]   pfb1_r, pwet1_r;
  logic signed [PROD_W-1:0]   dly_ext_s, gfb_ext_s, gwet_ext_s;
  logic signed [SAMPLE_W-1:0] term_fb_s, term_wet_s, sum_fb_s, sum_wet_s;
  logic signed [SAMPLE_W-1:0] out_r, fb_out_r;
  logic                       out_valid_r;

  assign cnt_next_s = cnt_r + 13'd1;

  // Fade/flush sequencer; advances only on sample strobes
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_r     <= ST_RUN;
      ramp_r      <= RAMP_MAX;
      delay_sel_r <= 13'd0;
      cnt_r       <= 13'd0;
    end else if (sample_en) begin
      case (state_r)
        ST_RUN: begin
          if (delay_req != delay_sel_r) state_r <= ST_FADE_OUT;
        end
        ST_FADE_OUT: begin
          if (ramp_r <= RAMP_STEP) begin
            ramp_r      <= 9'd0;
            state_r     <= ST_FLUSH;
            delay_sel_r <= delay_req;
            cnt_r       <= 13'd0;
          end else begin
            ramp_r <= ramp_r - RAMP_STEP;
          end
        end
        ST_FLUSH: begin
          // A zero-length delay still spends one silent sample in flush
          if (delay_req != delay_sel_r) begin
            delay_sel_r <= delay_req;
            cnt_r       <= 13'd0;
          end else if ((cnt_next_s == delay_sel_r) || (delay_sel_r == 13'd0)) begin
            state_r <= ST_FADE_IN;
          end else begin
            cnt_r <= cnt_next_s;
          end
        end
        ST_FADE_IN: begin
          if (delay_req != delay_sel_r) begin
            state_r <= ST_FADE_OUT;
          end else if (ramp_r + RAMP_STEP >= RAMP_MAX) begin
            ramp_r  <= RAMP_MAX;
            state_r <= ST_RUN;
          end else begin
            ramp_r <= ramp_r + RAMP_STEP;
          end
        end
        default: state_r <= ST_RUN;
      endcase
    end
  end

  assign dly_ext_s  = {{GAIN_W{dly0_r[SAMPLE_W-1]}}, dly0_r};
  assign gfb_ext_s  = {15'd0, gfb0_r};
  assign gwet_ext_s = {15'd0, gwet0_r};

  // Three-stage datapath: capture, multiply, saturating add
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      v0_r        <= 1'b0;
      v1_r        <= 1'b0;
      out_valid_r <= 1'b0;
      dry0_r      <= 16'sd0;
      dly0_r      <= 16'sd0;
      gfb0_r      <= 9'd0;
      gwet0_r     <= 9'd0;
      dry1_r      <= 16'sd0;
      pfb1_r      <= 24'sd0;
      pwet1_r     <= 24'sd0;
      out_r       <= 16'sd0;
      fb_out_r    <= 16'sd0;
    end else begin
      v0_r        <= sample_en;
      v1_r        <= v0_r;
      out_valid_r <= v1_r;
      if (sample_en) begin
        dry0_r  <= dry_in;
        dly0_r  <= delayed_in;
        gfb0_r  <= scale_gain(fb_gain, ramp_r);
        gwet0_r <= scale_gain(wet_gain, ramp_r);
      end
      if (v0_r) begin
        dry1_r  <= dry0_r;
        pfb1_r  <= dly_ext_s * gfb_ext_s;
        pwet1_r <= dly_ext_s * gwet_ext_s;
      end
      if (v1_r) begin
        out_r    <= sum_wet_s;
        fb_out_r <= sum_fb_s;
      end
    end
  end

  assign term_fb_s  = SAMPLE_W'(pfb1_r >>> GAIN_W);
  assign term_wet_s = SAMPLE_W'(pwet1_r >>> GAIN_W);

  sat_add16 u_sat_fb (
    .a   (dry1_r),
    .b   (term_fb_s),
    .sum (sum_fb_s)
  );

  sat_add16 u_sat_wet (
    .a   (dry1_r),
    .b   (term_wet_s),
    .sum (sum_wet_s)
  );

  assign delay_sel = delay_sel_r;
  assign fb_out    = fb_out_r;
  assign out       = out_r;
  assign out_valid = out_valid_r;

endmodule

// File: tb/tb_reverb_mix.sv
// Self-checking bench for reverb_mix: fixed vectors plus randomized traffic
// compared against a sample-level reference model of the fade/flush behaviour.
module tb_reverb_mix;

  logic        clk = 1'b0;
  logic        reset_n;
  logic        sample_en;
  logic [15:0] dry_in, delayed_in;
  logic [7:0]  fb_gain, wet_gain;
  logic [12:0] delay_req, delay_sel;
  logic [15:0] fb_out, out;
  logic        out_valid;

  reverb_mix dut (
    .clk        (clk),
    .reset_n    (reset_n),
    .sample_en  (sample_en),
    .dry_in     (dry_in),
    .delayed_in (delayed_in),
    .fb_gain    (fb_gain),
    .wet_gain   (wet_gain),
    .delay_req  (delay_req),
    .delay_sel  (delay_sel),
    .fb_out     (fb_out),
    .out        (out),
    .out_valid  (out_valid)
  );

  always #5 clk = ~clk;

  typedef struct { int due; int o; int f; } exp_t;
  typedef struct { int dry; int dly; int fbg; int wetg; int eo; int ef; } vec_t;

  exp_t exp_q[$];
  vec_t tab[10];

  int nvec = 0, nbad = 0, cyc = 0, nvalid = 0;
  int last_o = 0, last_f = 0;
  bit tab_use = 1'b0;
  int tab_o = 0, tab_f = 0;

  // Reference model: current gain scale, what the mixer is doing, selected delay,
  // and how many silent samples remain before the fade-in starts.
  localparam int STEADY = 0, DOWN = 1, HOLD = 2, UP = 3;
  int m_ramp, m_mode, m_sel, m_left;

  function automatic int sat16(int x);
    if (x > 32767) return 32767;
    if (x < -32768) return -32768;
    return x;
  endfunction

  function automatic int scaled(int d, int gain, int ramp);
    return (d * ((gain * ramp) >>> 8)) >>> 8;
  endfunction

  task automatic check(input string name, input int act, input int expv);
    nvec++;
    if (act !== expv) begin
      nbad++;
      $display("FAIL %s at cycle %0d: got %0d, expected %0d", name, cyc, act, expv);
    end
  endtask

  task automatic model_reset();
    m_ramp = 256; m_mode = STEADY; m_sel = 0; m_left = 0;
    exp_q.delete();
    last_o = 0; last_f = 0;
  endtask

  task automatic model_step(input int req);
    case (m_mode)
      STEADY: if (req != m_sel) m_mode = DOWN;
      DOWN: begin
        m_ramp = (m_ramp > 16) ? m_ramp - 16 : 0;
        if (m_ramp == 0) begin
          m_mode = HOLD; m_sel = req; m_left = (req == 0) ? 1 : req;
        end
      end
      HOLD: begin
        if (req != m_sel) begin
          m_sel = req; m_left = (req == 0) ? 1 : req;
        end else begin
          m_left--;
          if (m_left == 0) m_mode = UP;
        end
      end
      default: begin
        if (req != m_sel) m_mode = DOWN;
        else begin
          m_ramp += 16;
          if (m_ramp >= 256) begin m_ramp = 256; m_mode = STEADY; end
        end
      end
    endcase
  endtask

  task automatic tick();
    exp_t e;
    bit ev;
    int d, y;
    @(posedge clk);
    cyc++;
    if (reset_n && sample_en) begin
      d = $signed(dry_in);
      y = $signed(delayed_in);
      e.due = cyc + 2;
      if (tab_use) begin
        e.o = tab_o; e.f = tab_f;
      end else begin
        e.o = sat16(d + scaled(y, wet_gain, m_ramp));
        e.f = sat16(d + scaled(y, fb_gain, m_ramp));
      end
      exp_q.push_back(e);
      model_step(delay_req);
    end
    #1;
    ev = (exp_q.size() > 0) && (exp_q[0].due == cyc);
    check("out_valid", out_valid, ev);
    if (out_valid === 1'b1) nvalid++;
    if (ev) begin
      check("out", $signed(out), exp_q[0].o);
      check("fb_out", $signed(fb_out), exp_q[0].f);
      last_o = exp_q[0].o;
      last_f = exp_q[0].f;
      void'(exp_q.pop_front());
    end else begin
      check("out_hold", $signed(out), last_o);
      check("fb_out_hold", $signed(fb_out), last_f);
    end
    check("delay_sel", delay_sel, m_sel);
  endtask

  task automatic drive(input bit en, input int d, input int y, input int fg, input int wg, input int req);
    sample_en  = en;
    dry_in     = 16'(d);
    delayed_in = 16'(y);
    fb_gain    = 8'(fg);
    wet_gain   = 8'(wg);
    delay_req  = 13'(req);
  endtask

  function automatic int rnd16();
    return int'($urandom_range(0, 65535)) - 32768;
  endfunction

  task automatic run_rand(input int n, input int fg, input int wg, input int req);
    for (int i = 0; i < n; i++) begin
      drive(1'b1, rnd16(), rnd16(), fg, wg, req);
      tick();
    end
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int v0, req;
    bit found;

    tab[0] = '{30000, 30000, 255, 255, 32767, 32767};
    tab[1] = '{-30000, -30000, 255, 255, -32768, -32768};
    tab[2] = '{0, 1000, 64, 128, 500, 250};
    tab[3] = '{100, -1000, 64, 128, -400, -150};
    tab[4] = '{-5, 1, 0, 255, -5, -5};
    tab[5] = '{32767, -1, 255, 255, 32766, 32766};
    tab[6] = '{-32768, -1, 1, 0, -32768, -32768};
    tab[7] = '{1234, 256, 200, 16, 1250, 1434};
    tab[8] = '{0, 0, 255, 255, 0, 0};
    tab[9] = '{-1000, 32767, 128, 255, 31639, 15383};

    reset_n = 1'b0;
    drive(1'b0, 0, 0, 0, 0, 0);
    model_reset();
    repeat (3) tick();
    reset_n = 1'b1;
    repeat (2) tick();

    // Back-to-back vectors in steady state
    v0 = nvalid;
    for (int i = 0; i < 10; i++) begin
      tab_use = 1'b1; tab_o = tab[i].eo; tab_f = tab[i].ef;
      drive(1'b1, tab[i].dry, tab[i].dly, tab[i].fbg, tab[i].wetg, 0);
      tick();
    end
    tab_use = 1'b0;
    drive(1'b0, 0, 0, 0, 0, 0);
    repeat (4) tick();
    check("valid_pulse_count", nvalid - v0, 10);

    // Delay change 0 -> 4 from steady state
    run_rand(50, 200, 180, 4);

    // Delay change to 9, then interrupt its fade-in at ramp 128
    found = 1'b0;
    for (int i = 0; i < 200; i++) begin
      if (m_mode == UP && m_ramp == 128) begin found = 1'b1; break; end
      drive(1'b1, rnd16(), rnd16(), 230, 250, 9);
      tick();
    end
    check("fade_in_reached_within_bound", found, 1);
    run_rand(60, 230, 250, 2);

    // Randomized traffic with sporadic delay changes and strobe gaps
    req = 2;
    for (int i = 0; i < 2000; i++) begin
      if ($urandom_range(0, 149) == 0) req = int'($urandom_range(0, 6));
      drive($urandom_range(0, 3) != 0, rnd16(), rnd16(),
            int'($urandom_range(0, 255)), int'($urandom_range(0, 255)), req);
      tick();
    end
    drive(1'b0, 0, 0, 0, 0, req);
    repeat (4) tick();

    // Reset pulse with two samples still in the pipeline
    run_rand(2, 255, 255, req);
    reset_n = 1'b0;
    drive(1'b0, 0, 0, 0, 0, 5);
    model_reset();
    #1;
    check("rst_out", $signed(out), 0);
    check("rst_fb_out", $signed(fb_out), 0);
    check("rst_out_valid", out_valid, 0);
    check("rst_delay_sel", delay_sel, 0);
    tick();
    reset_n = 1'b1;

    // First sample after reset uses full ramp; delay_req 5 then starts a fade cycle
    tab_use = 1'b1; tab_o = 500; tab_f = 250;
    drive(1'b1, 0, 1000, 64, 128, 5);
    tick();
    tab_use = 1'b0;
    run_rand(50, 180, 140, 5);
    drive(1'b0, 0, 0, 0, 0, 5);
    repeat (5) tick();

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nbad);
    $finish;
  end

endmodule
